// File: rtl/timer_dev_pkg.sv
// Shared definitions for the memory-mapped timer: FSM states, register
// offsets inside the 16-byte window, CTRL field positions, MODE encodings
// and small helpers used by the register file.
package timer_dev_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

    // Word offsets (addr[3:2]) inside the register window
    localparam logic [1:0] OFF_CTRL     = 2'd0;
    localparam logic [1:0] OFF_PRESET   = 2'd1;
    localparam logic [1:0] OFF_COUNT    = 2'd2;
    localparam logic [1:0] OFF_UNMAPPED = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

    // MODE encodings; 2'b1x behaves as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    // Only the exact auto-reload code reloads; every other code is one-shot
    function automatic logic is_auto_reload(input logic [1:0] mode);
        return (mode == MODE_AUTO);
    endfunction

    // Byte-lane merge of a write into an existing 32-bit register
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_v[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_dev.sv
// Memory-mapped down-counting timer with a 3-register window
// (CTRL, PRESET, COUNT) and a registered interrupt request.
// Build option: define TIMER_BYTEEN_EN for byte-granular writes
// (CTRL then honours byteen[0] only); otherwise any nonzero byteen
// writes the whole word.
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    timer_state_e state_r;
    logic [3:0]   ctrl_r;
    logic [31:0]  preset_r;
    logic [31:0]  count_r;
    logic         pend_r;
    logic         irq_r;

    logic         in_window_s;
    logic [1:0]   offset_s;
    logic         write_s;
    logic         ctrl_wr_s;
    logic         preset_wr_s;
    logic [3:0]   ctrl_wval_s;
    logic [31:0]  preset_wval_s;
    logic [3:0]   ctrl_next_s;
    logic         pend_next_s;
    logic         force_idle_s;
    logic         unused_s;

    assign in_window_s  = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset_s     = addr[3:2];
    assign write_s      = in_window_s && (byteen != 4'b0000);
    assign ctrl_wr_s    = write_s && (offset_s == OFF_CTRL);
    assign preset_wr_s  = write_s && (offset_s == OFF_PRESET);
    assign force_idle_s = ctrl_wr_s && !ctrl_wval_s[CTRL_EN_BIT];
    assign unused_s     = ^addr[1:0];
    assign irq          = irq_r;

    // Value a CPU write would place into CTRL and PRESET
    always_comb begin
`ifdef TIMER_BYTEEN_EN
        if (byteen[0]) begin
            ctrl_wval_s = wdata[3:0];
        end else begin
            ctrl_wval_s = ctrl_r;
        end
        preset_wval_s = merge_bytes(preset_r, wdata, byteen);
`else
        ctrl_wval_s   = wdata[3:0];
        preset_wval_s = wdata;
`endif
    end

    // Next CTRL and PEND: a CPU write to CTRL beats the FSM's EN clear and PEND set
    always_comb begin
        ctrl_next_s = ctrl_r;
        pend_next_s = pend_r;
        if (ctrl_wr_s) begin
            ctrl_next_s = ctrl_wval_s;
            pend_next_s = 1'b0;
        end else if (state_r == ST_INT) begin
            pend_next_s = 1'b1;
            if (is_auto_reload(ctrl_r[CTRL_MODE_MSB:CTRL_MODE_LSB])) begin
                ctrl_next_s = ctrl_r;
            end else begin
                ctrl_next_s = ctrl_r & 4'b1110;
            end
        end else begin
            ctrl_next_s = ctrl_r;
            pend_next_s = pend_r;
        end
    end

    // Combinational read mux; zero outside the window and at the unmapped slot
    always_comb begin
        rdata = 32'd0;
        if (in_window_s) begin
            case (offset_s)
                OFF_CTRL:     rdata = {28'd0, ctrl_r};
                OFF_PRESET:   rdata = preset_r;
                OFF_COUNT:    rdata = count_r;
                OFF_UNMAPPED: rdata = 32'd0;
                default:      rdata = 32'd0;
            endcase
        end else begin
            rdata = 32'd0;
        end
    end

    // Register file, counting FSM and interrupt flop
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            ctrl_r   <= 4'd0;
            preset_r <= 32'd0;
            count_r  <= 32'd0;
            pend_r   <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            ctrl_r <= ctrl_next_s;
            pend_r <= pend_next_s;
            irq_r  <= pend_next_s & ctrl_next_s[CTRL_IM_BIT];
            if (preset_wr_s) begin
                preset_r <= preset_wval_s;
            end
            if (force_idle_s) begin
                // Disabling through CTRL stops the timer at once, COUNT held
                state_r <= ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (ctrl_r[CTRL_EN_BIT]) begin
                            state_r <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        count_r <= preset_r;
                        state_r <= ST_CNT;
                    end
                    ST_CNT: begin
                        if (!ctrl_r[CTRL_EN_BIT]) begin
                            state_r <= ST_IDLE;
                        end else if (count_r > 32'd1) begin
                            count_r <= count_r - 32'd1;
                        end else begin
                            count_r <= 32'd0;
                            state_r <= ST_INT;
                        end
                    end
                    ST_INT: begin
                        if (is_auto_reload(ctrl_r[CTRL_MODE_MSB:CTRL_MODE_LSB])) begin
                            state_r <= ST_LOAD;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: a behavioural model of the register
// map and counting rules, compared every cycle, plus directed scenarios
// with hand-computed expectations and a randomized stress phase.
module tb_timer_dev;

    localparam logic [31:0] BASE = 32'h0000_7F00;
    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_CNT  = 2;
    localparam int PH_INT  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    timer_dev #(.BASE_ADDR(BASE)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          phase;
        logic [3:0]  ctrl;
        logic [31:0] preset;
        logic [31:0] count;
        logic        pend;
    } mstate_t;

    mstate_t ms;

    // Reference behaviour for one clock edge
    function automatic mstate_t model_next(input mstate_t s, input logic rst,
                                           input logic [31:0] a, input logic [3:0] be,
                                           input logic [31:0] d);
        mstate_t n;
        bit wr;
        logic [3:0] newc;
        logic [31:0] base_v;
        n = s;
        base_v = BASE;
        if (rst) begin
            n.phase = PH_IDLE; n.ctrl = 4'd0; n.preset = 32'd0;
            n.count = 32'd0;   n.pend = 1'b0;
            return n;
        end
        if (s.phase == PH_IDLE) begin
            if (s.ctrl[0]) n.phase = PH_LOAD;
        end else if (s.phase == PH_LOAD) begin
            n.count = s.preset; n.phase = PH_CNT;
        end else if (s.phase == PH_CNT) begin
            if (!s.ctrl[0]) n.phase = PH_IDLE;
            else if (s.count > 32'd1) n.count = s.count - 32'd1;
            else begin n.count = 32'd0; n.phase = PH_INT; end
        end else begin
            n.pend = 1'b1;
            if (s.ctrl[2:1] == 2'b01) n.phase = PH_LOAD;
            else begin n.ctrl[0] = 1'b0; n.phase = PH_IDLE; end
        end
        wr = (a[31:4] == base_v[31:4]) && (be != 4'd0);
        if (wr && a[3:2] == 2'd0) begin
`ifdef TIMER_BYTEEN_EN
            newc = be[0] ? d[3:0] : s.ctrl;
`else
            newc = d[3:0];
`endif
            n.ctrl = newc;
            n.pend = 1'b0;
            if (!newc[0]) begin n.phase = PH_IDLE; n.count = s.count; end
        end
        if (wr && a[3:2] == 2'd1) begin
`ifdef TIMER_BYTEEN_EN
            for (int b = 0; b < 4; b++) if (be[b]) n.preset[8*b +: 8] = d[8*b +: 8];
`else
            n.preset = d;
`endif
        end
        return n;
    endfunction

    function automatic logic [31:0] model_read(input mstate_t s, input logic [31:0] a);
        logic [31:0] base_v;
        base_v = BASE;
        if (a[31:4] != base_v[31:4]) return 32'd0;
        case (a[3:2])
            2'd0:    return {28'd0, s.ctrl};
            2'd1:    return s.preset;
            2'd2:    return s.count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on the same edge as the DUT
    always @(posedge clk) ms <= model_next(ms, reset, addr, byteen, wdata);

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            check("irq_model", {31'd0, irq}, {31'd0, ms.pend & ms.ctrl[3]});
            check("rdata_model", rdata, model_read(ms, addr));
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        addr = a; byteen = be; wdata = d;
        @(negedge clk);
        byteen = 4'd0;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a; byteen = 4'd0;
        #1;
        check(name, rdata, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1; byteen = 4'd0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_irq(output int k);
        k = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (irq) begin k = i; break; end
        end
    endtask

    task automatic poll_count(input logic [31:0] target, output bit found);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            addr = BASE + 32'd8; byteen = 4'd0;
            #1;
            if (rdata == target) begin found = 1'b1; break; end
        end
    endtask

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        bit found;
        logic [31:0] r32;
        logic [3:0]  c4;
        int op;

        reset = 1'b1; addr = 32'd0; byteen = 4'd0; wdata = 32'd0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        read_check("rst_ctrl",   BASE,          32'd0);
        read_check("rst_preset", BASE + 32'd4,  32'd0);
        read_check("rst_count",  BASE + 32'd8,  32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);

        // Byte-enable write of PRESET
        do_write(BASE + 32'd4, 4'b0001, 32'hFFFF_FFFF);
`ifdef TIMER_BYTEEN_EN
        read_check("byteen_preset", BASE + 32'd4, 32'h0000_00FF);
`else
        read_check("byteen_preset", BASE + 32'd4, 32'hFFFF_FFFF);
`endif
        do_reset();

        // One-shot, PRESET=5: irq 8 cycles after the CTRL write edge
        do_write(BASE + 32'd4, 4'hF, 32'd5);
        do_write(BASE, 4'hF, 32'h9);
        wait_irq(k);
        check("oneshot_latency", k, 32'd8);
        read_check("oneshot_ctrl_en_clear", BASE, 32'h8);
        read_check("oneshot_count_zero", BASE + 32'd8, 32'd0);
        do_write(BASE, 4'hF, 32'h0);
        check("ctrl_write_clears_irq", {31'd0, irq}, 32'd0);

        // IM=0: no irq, COUNT reaches 0, EN cleared
        do_write(BASE + 32'd4, 4'hF, 32'd2);
        do_write(BASE, 4'hF, 32'h1);
        repeat (8) @(negedge clk);
        check("masked_irq", {31'd0, irq}, 32'd0);
        read_check("masked_count", BASE + 32'd8, 32'd0);
        read_check("masked_ctrl", BASE, 32'd0);

        // Auto-reload, PRESET=3: period 5
        do_write(BASE + 32'd4, 4'hF, 32'd3);
        do_write(BASE, 4'hF, 32'hB);
        wait_irq(k);
        check("auto_first_latency", k, 32'd6);
        do_write(BASE, 4'hF, 32'hB);
        check("auto_irq_cleared", {31'd0, irq}, 32'd0);
        wait_irq(k);
        check("auto_period", k, 32'd4);

        // Mid-count PRESET write leaves COUNT alone; next reload uses it
        do_write(BASE + 32'd4, 4'hF, 32'd10);
        poll_count(32'd7, found);
        check("reach_count_7", {31'd0, found}, 32'd1);
        do_write(BASE + 32'd4, 4'hF, 32'd100);
        read_check("count_after_preset_write", BASE + 32'd8, 32'd6);
        poll_count(32'd100, found);
        check("reload_100", {31'd0, found}, 32'd1);

        // Unmapped, out of window, COUNT read-only
        read_check("unmapped_read", BASE + 32'd12, 32'd0);
        read_check("above_window", BASE + 32'd16, 32'd0);
        read_check("below_window", BASE - 32'd4, 32'd0);
        do_reset();
        do_write(BASE + 32'd8, 4'hF, 32'd1234);
        read_check("count_write_ignored", BASE + 32'd8, 32'd0);

        // Reset in the middle of counting
        do_write(BASE + 32'd4, 4'hF, 32'd50);
        do_write(BASE, 4'hF, 32'hB);
        repeat (10) @(negedge clk);
        do_reset();
        read_check("midrst_ctrl",   BASE,         32'd0);
        read_check("midrst_preset", BASE + 32'd4, 32'd0);
        read_check("midrst_count",  BASE + 32'd8, 32'd0);
        repeat (60) @(negedge clk);
        check("midrst_irq", {31'd0, irq}, 32'd0);

        // Randomized stress against the model
        for (int it = 0; it < 2000; it++) begin
            op = $urandom_range(0, 99);
            if (op < 3) begin
                do_reset();
            end else if (op < 20) begin
                r32 = $urandom;
                c4 = r32[3:0];
                c4[0] = ($urandom_range(0, 3) != 0);
                do_write(BASE, 4'($urandom_range(1, 15)), {r32[31:4], c4});
            end else if (op < 35) begin
                do_write(BASE + 32'd4, 4'($urandom_range(1, 15)), 32'($urandom_range(0, 12)));
            end else if (op < 40) begin
                do_write(BASE + 32'd8, 4'hF, $urandom);
            end else if (op < 43) begin
                do_write(BASE + 32'd12, 4'hF, $urandom);
            end else if (op < 47) begin
                do_write(BASE + 32'h100 + 32'($urandom_range(0, 3) * 4), 4'hF, $urandom);
            end else begin
                k = $urandom_range(0, 5);
                if (k < 4) addr = BASE + 32'(k * 4);
                else if (k == 4) addr = BASE + 32'h40;
                else addr = $urandom;
                byteen = 4'd0;
                @(negedge clk);
            end
        end

        @(negedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_dev.md
TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_7F00, word-aligned base of the 3-word register window.
REQ-002 SHALL have input clk, 1 bit: clock; all state updates on posedge clk.
REQ-003 SHALL have input reset, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have input addr, 32 bits: bus byte address from CPU data port; only addr[3:2] decoded inside window.
REQ-005 SHALL have input byteen, 4 bits: write byte enables; any bit set with in-window addr = write.
REQ-006 SHALL have input wdata, 32 bits: write data.
REQ-007 SHALL have output rdata, 32 bits: combinational read data of addressed register; 0 outside window.
REQ-008 SHALL have output irq, 1 bit: registered interrupt request to CPU interrupt input.

Function
REQ-009 SHALL decode offset 0 = CTRL (R/W, bits [3:0] only, [31:4] read 0), offset 4 = PRESET (R/W), offset 8 = COUNT (read-only, writes ignored), offset 12 = unmapped (reads 0, writes ignored).
REQ-010 SHALL define CTRL[0] = EN, CTRL[2:1] = MODE (00 one-shot, 01 auto-reload, 1x treated as one-shot), CTRL[3] = IM (interrupt mask, 1 = enabled).
REQ-011 SHALL implement FSM IDLE, LOAD, CNT, INT, advancing one state per cycle at most.
REQ-012 IDLE: EN=1 -> LOAD; else stay.
REQ-013 LOAD: COUNT <= PRESET; -> CNT.
REQ-014 CNT: EN=0 -> IDLE with COUNT held; COUNT>1 -> COUNT-1, stay; COUNT<=1 -> COUNT <= 0, -> INT (PRESET=0 reaches INT one cycle after LOAD).
REQ-015 INT: set PEND; MODE one-shot -> clear EN, -> IDLE; MODE auto-reload -> LOAD.
REQ-016 irq SHALL equal registered PEND & IM, asserted the cycle after INT.
REQ-017 Any write to CTRL SHALL clear PEND in the same posedge; a PEND set and CTRL write in the same cycle -> CTRL write wins (PEND cleared).
REQ-018 CPU write to CTRL.EN SHALL take priority over FSM EN clear in INT.
REQ-019 PRESET write during CNT SHALL not alter COUNT; takes effect at next LOAD.
REQ-020 COUNT SHALL be unsigned 32 bit; no wrap below 0.
REQ-021 Write to CTRL with EN=0 during any state SHALL force IDLE next cycle.

Reset
REQ-022 On reset: state IDLE, CTRL=0, PRESET=0, COUNT=0, PEND=0, irq=0; reset asserted mid-count SHALL abort counting with no irq.

Configuration
REQ-023 With TIMER_BYTEEN_EN defined, writes SHALL update only bytes whose byteen bit is set (CTRL honours byteen[0] only).
REQ-024 Without TIMER_BYTEEN_EN, any nonzero byteen SHALL write the full 32-bit word.

Structure
REQ-025 Shared package SHALL hold FSM state enum, register offset constants, CTRL bit-position and MODE constants.
REQ-026 Single module; no sub-module required (register file and FSM are small).

Verification
REQ-027 Reset, PRESET=5, CTRL=4'b1001 -> irq rises exactly 8 cycles after CTRL write posedge (LOAD, 5 CNT, INT, irq), EN reads 0 afterwards.
REQ-028 CTRL=4'b1011, PRESET=3 -> PEND periodic every 5 cycles; write CTRL=4'b1011 clears irq next cycle, counting continues.
REQ-029 CTRL=4'b0001 (IM=0), PRESET=2 -> irq stays 0, COUNT reaches 0, CTRL read shows EN=0.
REQ-030 Mid-count write PRESET=100 with COUNT=7 -> COUNT continues 6,5,...; reload in auto mode loads 100.
REQ-031 Mid-count reset -> all reads 0, irq 0; byteen=4'b0001 write of 32'hFFFF_FFFF to PRESET -> 32'h0000_00FF with TIMER_BYTEEN_EN, 32'hFFFF_FFFF without.
REQ-032 Read addr BASE_ADDR+12 and addr outside window -> rdata 0; write to COUNT -> no change.
